// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin arbiter sharing the dram0 peek/poke port among NUM_REQ requesters
// Optional read watchdog: define DRAM_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module dram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 28,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*32-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic [31:0]                   rdata_o,
    output logic                          err_o,
    output logic                          busy_o,
    output logic [2:0]                    grant_o,
    output logic [ADDR_WIDTH-1:0]         dram0_addr_o,
    output logic [31:0]                   dram0_data_o,
    output logic                          dram0_we_o,
    output logic                          dram0_pop_o,
    input  logic [31:0]                   dram0_data_i,
    input  logic                          dram0_ack_i
);

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("dram_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t                  state;
    logic [2:0]              rr_ptr;
    logic                    lat_we;
    logic                    pick_valid;
    logic [2:0]              pick_idx;
    logic                    pick_we;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [31:0]             pick_wdata;
    logic [NUM_REQ-1:0]      grant_onehot;

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;
`endif

    // Two passes give the rr_ptr-upward search with wrap: first rr_ptr..N-1, then 0..rr_ptr-1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_valid && req_i[j] && j >= int'(rr_ptr)) begin
                pick_valid = 1'b1;
                pick_idx   = 3'(j);
                pick_we    = we_i[j];
                pick_addr  = addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = wdata_i[j*32 +: 32];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_valid && req_i[j] && j < int'(rr_ptr)) begin
                pick_valid = 1'b1;
                pick_idx   = 3'(j);
                pick_we    = we_i[j];
                pick_addr  = addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = wdata_i[j*32 +: 32];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (int'(grant_o) == j) grant_onehot[j] = 1'b1;
        end
    end

    assign busy_o      = (state != ST_IDLE);
    assign dram0_we_o  = (state == ST_ISSUE) && lat_we;
    assign dram0_pop_o = (state == ST_ISSUE) && !lat_we;

`ifndef DRAM_ARB_TIMEOUT_EN
    assign err_o = 1'b0;
`endif

    // ack_o (and err_o) default low and are loaded on entry to ST_DONE, so they pulse for exactly that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant_o      <= '0;
            ack_o        <= '0;
            rdata_o      <= '0;
            dram0_addr_o <= '0;
            dram0_data_o <= '0;
            lat_we       <= 1'b0;
`ifdef DRAM_ARB_TIMEOUT_EN
            err_o        <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            ack_o <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            err_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_o      <= pick_idx;
                        dram0_addr_o <= pick_addr;
                        dram0_data_o <= pick_wdata;
                        lat_we       <= pick_we;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef DRAM_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    if (lat_we) begin
                        ack_o <= grant_onehot;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (dram0_ack_i) begin
                        rdata_o <= dram0_data_i;
                        ack_o   <= grant_onehot;
                        state   <= ST_DONE;
                    end
`ifdef DRAM_ARB_TIMEOUT_EN
                    else if (wd_cnt == WD_LIMIT) begin
                        rdata_o <= 32'hdeadbeef;
                        err_o   <= 1'b1;
                        ack_o   <= grant_onehot;
                        state   <= ST_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                ST_DONE: begin
                    rr_ptr <= (int'(grant_o) == NUM_REQ - 1) ? 3'd0 : grant_o + 3'd1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - scoreboard testbench for dram_port_arbiter (covers DRAM_ARB_TIMEOUT_EN when defined)
module tb_dram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 28;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_i, we_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*32-1:0]  wdata_i;
    logic [NR-1:0]     ack_o;
    logic [31:0]       rdata_o;
    logic              err_o, busy_o;
    logic [2:0]        grant_o;
    logic [AW-1:0]     dram0_addr_o;
    logic [31:0]       dram0_data_o, dram0_data_i;
    logic              dram0_we_o, dram0_pop_o, dram0_ack_i;

    always #5 clk = ~clk;

    dram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o), .grant_o(grant_o),
        .dram0_addr_o(dram0_addr_o), .dram0_data_o(dram0_data_o), .dram0_we_o(dram0_we_o),
        .dram0_pop_o(dram0_pop_o), .dram0_data_i(dram0_data_i), .dram0_ack_i(dram0_ack_i)
    );

    typedef struct {
        int          idx;
        bit          we;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          req_cyc;
        int          strobes;
        int          lat;
    } txn_t;

    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pend = 0;
    int          rd_lat = 2;
    int          seq = 0;
    int          reissue_left[NR];
    bit          spur_issue = 1'b0;
    logic [31:0] resp_data = '0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int idx, input bit we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input bit err, input int lat);
        txn_t t;
        t.idx = idx; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.err = err; t.req_cyc = cyc; t.strobes = 0; t.lat = lat;
        exp_q.push_back(t);
        req_i[idx] = 1'b1;
        we_i[idx] = we;
        addr_i[idx*AW +: AW] = addr;
        wdata_i[idx*32 +: 32] = wdata;
    endtask

    // One clock: sample at negedge, score strobes/acks, then drive requester and dram0 inputs.
    task automatic tick();
        txn_t        t;
        logic [NR-1:0] oh;
        bit          pop_seen;
        @(negedge clk);
        cyc++;
        pop_seen = dram0_pop_o;
        if (dram0_we_o || dram0_pop_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'({dram0_we_o, dram0_pop_o}), 64'(0));
            end else begin
                t = exp_q[0];
                check("strobe_kind", 64'({dram0_we_o, dram0_pop_o}), 64'({t.we, !t.we}));
                check("strobe_addr", 64'(dram0_addr_o), 64'(t.addr));
                if (t.we) check("strobe_wdata", 64'(dram0_data_o), 64'(t.wdata));
                else resp_data = t.rdata;
                t.strobes++;
                exp_q[0] = t;
            end
        end
        if (ack_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'(ack_o), 64'(0));
            end else begin
                t = exp_q.pop_front();
                oh = '0;
                oh[t.idx] = 1'b1;
                if (!t.we) last_rdata = t.rdata;
                check("ack_onehot", 64'(ack_o), 64'(oh));
                check("grant", 64'(grant_o), 64'(t.idx));
                check("rdata", 64'(rdata_o), 64'(last_rdata));
                check("err", 64'(err_o), 64'(t.err));
                check("strobe_count", 64'(t.strobes), 64'(1));
                // latency counted in edges, the last one being the edge that samples ack_o
                if (t.lat > 0) check("latency", 64'(cyc - t.req_cyc + 1), 64'(t.lat));
                if (reissue_left[t.idx] > 0) begin
                    reissue_left[t.idx]--;
                    seq++;
                    post(t.idx, t.idx == 0, AW'(28'h100 + seq), 32'ha5a50000 + 32'(seq),
                         32'h5a5a0000 + 32'(seq), 1'b0, 0);
                end else begin
                    req_i[t.idx] = 1'b0;
                end
            end
        end
        dram0_ack_i = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                dram0_ack_i = 1'b1;
                dram0_data_i = resp_data;
            end
        end
        if (pop_seen) begin
            if (spur_issue) begin
                dram0_ack_i = 1'b1;
                dram0_data_i = 32'hbad0bad0;
            end
            pend = rd_lat;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("cycle_budget", 64'(n), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        dram0_ack_i = 1'b0; dram0_data_i = '0;
        for (int i = 0; i < NR; i++) reissue_left[i] = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_ack", 64'(ack_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_grant", 64'(grant_o), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_addr", 64'(dram0_addr_o), 64'(0));
        check("rst_data", 64'(dram0_data_o), 64'(0));
        check("rst_strobes", 64'({dram0_we_o, dram0_pop_o}), 64'(0));

        // single write, then single read with 5-cycle dram latency
        post(0, 1'b1, 28'h0000123, 32'hcafebabe, 32'h0, 1'b0, 3);
        run_until_idle(20);
        check("hold_addr", 64'(dram0_addr_o), 64'(28'h0000123));
        check("hold_data", 64'(dram0_data_o), 64'(32'hcafebabe));
        rd_lat = 5;
        post(1, 1'b0, 28'h0ABCDEF, 32'h0, 32'h12345678, 1'b0, 8);
        run_until_idle(30);

        // stray dram0 acks in ST_IDLE and in ST_ISSUE are ignored
        dram0_ack_i = 1'b1;
        dram0_data_i = 32'hfeedf00d;
        tick();
        tick();
        check("spur_idle_busy", 64'(busy_o), 64'(0));
        check("spur_idle_rdata", 64'(rdata_o), 64'(32'h12345678));
        spur_issue = 1'b1;
        rd_lat = 2;
        post(1, 1'b0, 28'h0000456, 32'h0, 32'h600dd00d, 1'b0, 5);
        run_until_idle(30);
        spur_issue = 1'b0;

        // both requesting, each reissuing once on ack: expected order 0,1,0,1
        reissue_left[0] = 1;
        reissue_left[1] = 1;
        post(0, 1'b1, 28'h0000200, 32'h11111111, 32'h0, 1'b0, 0);
        post(1, 1'b0, 28'h0000201, 32'h0, 32'h22222222, 1'b0, 0);
        run_until_idle(100);

        // reset in the middle of a read; rr pointer moved to 1 beforehand
        post(0, 1'b1, 28'h0000300, 32'h33333333, 32'h0, 1'b0, 3);
        run_until_idle(20);
        rd_lat = 0;
        post(1, 1'b0, 28'h0000301, 32'h0, 32'h0, 1'b0, 0);
        repeat (4) tick();
        check("mid_read_busy", 64'(busy_o), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        req_i = '0;
        tick();
        rst = 1'b0;
        last_rdata = '0;
        tick();
        dram0_ack_i = 1'b1;
        dram0_data_i = 32'h77777777;
        tick();
        tick();
        check("post_rst_busy", 64'(busy_o), 64'(0));
        check("post_rst_ack", 64'(ack_o), 64'(0));
        check("post_rst_rdata", 64'(rdata_o), 64'(0));
        rd_lat = 2;
        post(0, 1'b1, 28'h0000310, 32'h31313131, 32'h0, 1'b0, 3);
        post(1, 1'b1, 28'h0000311, 32'h32323232, 32'h0, 1'b0, 0);
        run_until_idle(40);

`ifdef DRAM_ARB_TIMEOUT_EN
        rd_lat = 0;
        post(0, 1'b0, 28'h0000400, 32'h0, 32'hdeadbeef, 1'b1, 19);
        run_until_idle(60);
        rd_lat = 3;
        post(1, 1'b0, 28'h0000401, 32'h0, 32'h44444444, 1'b0, 6);
        run_until_idle(30);
`else
        rd_lat = 20;
        post(0, 1'b0, 28'h0000400, 32'h0, 32'h55555555, 1'b0, 23);
        run_until_idle(60);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
